// File: rtl/mem_port_arbiter.sv
// Shares one byte-write, word-read memory port between instruction fetch and data access.
// Each store is split into one write beat per byte. Loads and fetches take a single read cycle.
module mem_port_arbiter #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [1:0]        dm_size_i,
    input  logic [AWIDTH-1:0] dm_addr_i,
    input  logic [DWIDTH-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DWIDTH-1:0] dm_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e            state_q;
    logic              lastGntDm_q;
    logic              ownerDm_q;
    logic [AWIDTH-1:0] addr_q;
    logic [1:0]        size_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [1:0]        beat_q;

    logic [AWIDTH-1:0] memAddr_q;
    logic [DWIDTH-1:0] memData_q;
    logic              memReadEn_q;
    logic              memWriteEn_q;
    logic              ifRvalid_q;
    logic              dmRvalid_q;
    logic [DWIDTH-1:0] ifRdata_q;
    logic [DWIDTH-1:0] dmRdata_q;

    logic              grantIf;
    logic              grantDm;
    logic              isStore;
    logic [AWIDTH-1:0] reqAddr;
    logic [1:0]        nextBeat;
    logic [1:0]        lastBeat;
    logic [7:0]        nextByte;
    logic [DWIDTH-1:0] readMask;

    // Grants are gated by reset so every output reads zero while reset is held.
    always_comb begin
        grantDm  = rst && (state_q == IDLE) && dm_req_i && (!if_req_i || !lastGntDm_q);
        grantIf  = rst && (state_q == IDLE) && if_req_i && (!dm_req_i || lastGntDm_q);
        isStore  = grantDm && dm_we_i;
        reqAddr  = grantDm ? dm_addr_i : if_addr_i;
        nextBeat = beat_q + 2'd1;
        nextByte = 8'(wdata_q >> {nextBeat, 3'b000});
        lastBeat = 2'd3;
        readMask = '1;
        case (size_q)
            2'b00: begin
                lastBeat = 2'd0;
                readMask = {{(DWIDTH-8){1'b0}}, 8'hFF};
            end
            2'b01: begin
                lastBeat = 2'd1;
                readMask = {{(DWIDTH-16){1'b0}}, 16'hFFFF};
            end
            default: begin
                lastBeat = 2'd3;
                readMask = '1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lastGntDm_q  <= 1'b0;
            ownerDm_q    <= 1'b0;
            addr_q       <= '0;
            size_q       <= 2'b00;
            wdata_q      <= '0;
            beat_q       <= 2'd0;
            memAddr_q    <= '0;
            memData_q    <= '0;
            memReadEn_q  <= 1'b0;
            memWriteEn_q <= 1'b0;
            ifRvalid_q   <= 1'b0;
            dmRvalid_q   <= 1'b0;
            ifRdata_q    <= '0;
            dmRdata_q    <= '0;
        end else begin
            ifRvalid_q <= 1'b0;
            dmRvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grantDm || grantIf) begin
                        ownerDm_q   <= grantDm;
                        lastGntDm_q <= grantDm;
                        addr_q      <= reqAddr;
                        size_q      <= grantDm ? dm_size_i : 2'b10;
                        wdata_q     <= dm_wdata_i;
                        beat_q      <= 2'd0;
                        memAddr_q   <= reqAddr;
                        if (isStore) begin
                            memWriteEn_q <= 1'b1;
                            memData_q    <= {{(DWIDTH-8){1'b0}}, dm_wdata_i[7:0]};
                            state_q      <= WRITE;
                        end else begin
                            memReadEn_q <= 1'b1;
                            state_q     <= READ;
                        end
                    end
                end
                READ: begin
                    if (ownerDm_q) begin
                        dmRdata_q  <= mem_data_i & readMask;
                        dmRvalid_q <= 1'b1;
                    end else begin
                        ifRdata_q  <= mem_data_i & readMask;
                        ifRvalid_q <= 1'b1;
                    end
                    memReadEn_q <= 1'b0;
                    memAddr_q   <= '0;
                    state_q     <= RESP;
                end
                WRITE: begin
                    if (beat_q == lastBeat) begin
                        memWriteEn_q <= 1'b0;
                        memAddr_q    <= '0;
                        memData_q    <= '0;
                        dmRdata_q    <= '0;
                        dmRvalid_q   <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        beat_q    <= nextBeat;
                        memAddr_q <= addr_q + {{(AWIDTH-2){1'b0}}, nextBeat};
                        memData_q <= {{(DWIDTH-8){1'b0}}, nextByte};
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_gnt_o       = grantIf;
    assign dm_gnt_o       = grantDm;
    assign if_rvalid_o    = ifRvalid_q;
    assign dm_rvalid_o    = dmRvalid_q;
    assign if_rdata_o     = ifRdata_q;
    assign dm_rdata_o     = dmRdata_q;
    assign mem_addr_o     = memAddr_q;
    assign mem_data_o     = memData_q;
    assign mem_read_en_o  = memReadEn_q;
    assign mem_write_en_o = memWriteEn_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a byte memory with combinational word reads, plus a
// byte-level reference memory that predicts load data, latencies and write beats.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [1:0]  dm_size_i = 2'b10;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic        dm_gnt_o;
    logic        dm_rvalid_o;
    logic [31:0] dm_rdata_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_en_o;
    logic        mem_write_en_o;
    logic [31:0] mem_data_i;

    int assertCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_size_i(dm_size_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
        .mem_data_i(mem_data_i)
    );

    // Memory environment: 4 KiB indexed by the low address bits, plus a log of byte writes.
    logic [7:0]  envMem [0:4095];
    logic [7:0]  refMem [0:4095];
    logic        clearEn = 1'b0;
    logic        preloadEn = 1'b0;
    logic [11:0] preloadAddr = '0;
    logic [31:0] preloadData = '0;
    int          wrCount = 0;
    logic [31:0] logAddr [0:15];
    logic [7:0]  logData [0:15];
    wire  [11:0] ra = mem_addr_o[11:0];

    assign mem_data_i = {envMem[ra + 12'd3], envMem[ra + 12'd2], envMem[ra + 12'd1], envMem[ra]};

    always @(posedge clk) begin
        if (clearEn) begin
            for (int i = 0; i < 4096; i++) envMem[i] <= 8'h00;
        end
        if (preloadEn) begin
            for (int k = 0; k < 4; k++) envMem[preloadAddr + 12'(k)] <= preloadData[8*k +: 8];
        end
        if (mem_write_en_o) begin
            envMem[mem_addr_o[11:0]] <= mem_data_o[7:0];
            logAddr[wrCount % 16]    <= mem_addr_o;
            logData[wrCount % 16]    <= mem_data_o[7:0];
            wrCount                  <= wrCount + 1;
        end
    end

    wire [133:0] allOut = {if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
                           mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o};

    function automatic int nBytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [1:0] size);
        logic [11:0] a;
        logic [31:0] w;
        a = addr[11:0];
        w = {refMem[a + 12'd3], refMem[a + 12'd2], refMem[a + 12'd1], refMem[a]};
        if (size == 2'b00) return w & 32'h0000_00FF;
        if (size == 2'b01) return w & 32'h0000_FFFF;
        return w;
    endfunction

    task automatic modelStore(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        for (int i = 0; i < nBytes(size); i++) refMem[addr[11:0] + 12'(i)] = wdata[8*i +: 8];
    endtask

    task automatic clearMem;
        clearEn = 1'b1;
        @(posedge clk); #1;
        clearEn = 1'b0;
        for (int i = 0; i < 4096; i++) refMem[i] = 8'h00;
    endtask

    task automatic preloadWord(input logic [31:0] addr, input logic [31:0] word);
        preloadAddr = addr[11:0];
        preloadData = word;
        preloadEn = 1'b1;
        @(posedge clk); #1;
        preloadEn = 1'b0;
        modelStore(addr, 2'b10, word);
    endtask

    // Runs one request from the drive point just after a posedge; returns with the
    // observed latency (grant cycle to rvalid cycle) and response data.
    task automatic runTxn(input bit isDm, input bit we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output bit done, output int lat, output logic [31:0] rdata,
                          output bit sawReadEn);
        bit gotGnt;
        gotGnt = 1'b0;
        done = 1'b0;
        lat = 0;
        rdata = 'x;
        sawReadEn = 1'b0;
        if (isDm) begin
            dm_req_i = 1'b1; dm_we_i = we; dm_size_i = size; dm_addr_i = addr; dm_wdata_i = wdata;
        end else begin
            if_req_i = 1'b1; if_addr_i = addr;
        end
        for (int c = 0; c < 30 && !gotGnt; c++) begin
            @(negedge clk);
            if (isDm ? dm_gnt_o : if_gnt_o) gotGnt = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (gotGnt) begin
            @(posedge clk); #1;
            dm_req_i = 1'b0;
            if_req_i = 1'b0;
            dm_wdata_i = $urandom;
            for (int c = 1; c <= 12 && !done; c++) begin
                @(negedge clk);
                if (c == 1) sawReadEn = mem_read_en_o;
                if (isDm ? dm_rvalid_o : if_rvalid_o) begin
                    done = 1'b1;
                    lat = c;
                    rdata = isDm ? dm_rdata_o : if_rdata_o;
                end
                @(posedge clk); #1;
            end
        end
        dm_req_i = 1'b0;
        if_req_i = 1'b0;
    endtask

    task automatic test_reset;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_size_i = 2'b10; dm_addr_i = 32'h0100_0000;
        if_req_i = 1'b1; if_addr_i = 32'h0100_0000;
        repeat (2) @(negedge clk);
        assertCount++;
        if (allOut !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got %h, expected all zero", allOut);
        end
    endtask

    task automatic test_contention;
        int gntSeq[$];
        int gntCyc[$];
        int both;
        int got;
        int expSeq[4] = '{1, 0, 1, 0};
        both = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dm_gnt_o && if_gnt_o) both++;
            if (dm_gnt_o) begin gntSeq.push_back(1); gntCyc.push_back(c); end
            else if (if_gnt_o) begin gntSeq.push_back(0); gntCyc.push_back(c); end
            if (gntSeq.size() == 4) break;
        end
        @(posedge clk); #1;
        dm_req_i = 1'b0;
        if_req_i = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        for (int i = 0; i < 4; i++) begin
            got = (i < gntSeq.size()) ? gntSeq[i] : -1;
            assertCount++;
            if (got != expSeq[i]) begin
                failCount++;
                $display("[TB] FAIL contention_order[%0d]: got %0d, expected %0d (1=DM 0=IF)", i, got, expSeq[i]);
            end
        end
        for (int i = 1; i < gntCyc.size(); i++) begin
            assertCount++;
            if (gntCyc[i] - gntCyc[i-1] != 3) begin
                failCount++;
                $display("[TB] FAIL contention_spacing[%0d]: got %0d cycles, expected 3", i, gntCyc[i] - gntCyc[i-1]);
            end
        end
        assertCount++;
        if (both != 0) begin
            failCount++;
            $display("[TB] FAIL contention_double_grant: got %0d cycles with both grants, expected 0", both);
        end
        assertCount++;
        if (dm_rdata_o !== modelLoad(32'h0100_0000, 2'b10) || if_rdata_o !== modelLoad(32'h0100_0000, 2'b10)) begin
            failCount++;
            $display("[TB] FAIL contention_rdata: got dm %h if %h, expected %h", dm_rdata_o, if_rdata_o,
                     modelLoad(32'h0100_0000, 2'b10));
        end
    endtask

    task automatic test_fetch;
        bit done;
        bit sawRe;
        int lat;
        logic [31:0] rd;
        runTxn(1'b0, 1'b0, 2'b10, 32'h0100_0000, 32'h0, done, lat, rd, sawRe);
        assertCount++;
        if (!done || lat != 2 || !sawRe || rd !== modelLoad(32'h0100_0000, 2'b10)) begin
            failCount++;
            $display("[TB] FAIL fetch: got done=%0b lat=%0d readEn=%0b data=%h, expected 1/2/1/%h",
                     done, lat, sawRe, rd, modelLoad(32'h0100_0000, 2'b10));
        end
        @(negedge clk);
        assertCount++;
        if (if_rvalid_o !== 1'b0 || mem_read_en_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL fetch_pulse: got rvalid=%0b readEn=%0b after response, expected 0/0", if_rvalid_o, mem_read_en_o);
        end
        @(posedge clk); #1;
    endtask

    // Issues a store and checks latency, zero response data and every logged write beat.
    task automatic doStoreCheck(input string name, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        bit done;
        bit sawRe;
        int lat;
        int start;
        int n;
        logic [31:0] rd;
        logic [31:0] expAddr;
        n = nBytes(size);
        start = wrCount;
        runTxn(1'b1, 1'b1, size, addr, wdata, done, lat, rd, sawRe);
        modelStore(addr, size, wdata);
        assertCount++;
        if (!done || lat != n + 1 || rd !== 32'h0 || wrCount - start != n) begin
            failCount++;
            $display("[TB] FAIL %s: got done=%0b lat=%0d rdata=%h beats=%0d, expected 1/%0d/0/%0d",
                     name, done, lat, rd, wrCount - start, n + 1, n);
        end
        for (int i = 0; i < n && i < wrCount - start; i++) begin
            expAddr = addr + 32'(i);
            assertCount++;
            if (logAddr[(start + i) % 16] !== expAddr || logData[(start + i) % 16] !== wdata[8*i +: 8]) begin
                failCount++;
                $display("[TB] FAIL %s_beat%0d: got %h<=%h, expected %h<=%h", name, i,
                         logAddr[(start + i) % 16], logData[(start + i) % 16], expAddr, wdata[8*i +: 8]);
            end
        end
    endtask

    task automatic doLoadCheck(input string name, input logic [1:0] size, input logic [31:0] addr);
        bit done;
        bit sawRe;
        int lat;
        logic [31:0] rd;
        logic [31:0] exp;
        exp = modelLoad(addr, size);
        runTxn(1'b1, 1'b0, size, addr, 32'h0, done, lat, rd, sawRe);
        assertCount++;
        if (!done || lat != 2 || rd !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got done=%0b lat=%0d data=%h, expected 1/2/%h", name, done, lat, rd, exp);
        end
    endtask

    task automatic test_store_load;
        doStoreCheck("word_store", 2'b10, 32'h0100_0010, 32'hDEAD_BEEF);
        doLoadCheck("word_load", 2'b10, 32'h0100_0010);
    endtask

    task automatic test_sub_word_loads;
        doLoadCheck("byte_load", 2'b00, 32'h0100_0011);
        doLoadCheck("half_load", 2'b01, 32'h0100_0011);
        doLoadCheck("size3_load", 2'b11, 32'h0100_0011);
    endtask

    task automatic test_misaligned_half;
        doStoreCheck("misaligned_half", 2'b01, 32'h0100_0003, 32'hCAFE_1234);
        doLoadCheck("misaligned_half_load", 2'b01, 32'h0100_0003);
    endtask

    task automatic test_wrap;
        doStoreCheck("wrap_store", 2'b10, 32'hFFFF_FFFE, 32'h1122_3344);
        doLoadCheck("wrap_load", 2'b01, 32'h0000_0000);
    endtask

    task automatic test_random;
        bit isDm;
        bit we;
        logic [1:0] size;
        logic [31:0] addr;
        bit done;
        bit sawRe;
        int lat;
        logic [31:0] rd;
        logic [31:0] exp;
        for (int t = 0; t < 30; t++) begin
            isDm = ($urandom_range(0, 3) != 0);
            we = isDm && $urandom_range(0, 1);
            size = 2'($urandom_range(0, 3));
            addr = 32'h0100_0000 + 32'($urandom_range(0, 60));
            if (we) begin
                doStoreCheck("random_store", size, addr, $urandom);
            end else begin
                exp = modelLoad(addr, isDm ? size : 2'b10);
                runTxn(isDm, 1'b0, size, addr, 32'h0, done, lat, rd, sawRe);
                assertCount++;
                if (!done || lat != 2 || rd !== exp) begin
                    failCount++;
                    $display("[TB] FAIL random_read(%s): got done=%0b lat=%0d data=%h, expected 1/2/%h",
                             isDm ? "dm" : "if", done, lat, rd, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_store;
        bit gotGnt;
        int rvalidSeen;
        logic [31:0] wdata;
        logic [31:0] memWord;
        logic [31:0] expWord;
        wdata = 32'hA5C3_9617;
        expWord = {refMem[12'h023], refMem[12'h022], wdata[15:0]};
        gotGnt = 1'b0;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_size_i = 2'b10; dm_addr_i = 32'h0100_0020; dm_wdata_i = wdata;
        for (int c = 0; c < 30 && !gotGnt; c++) begin
            @(negedge clk);
            if (dm_gnt_o) gotGnt = 1'b1;
            else begin @(posedge clk); #1; end
        end
        assertCount++;
        if (!gotGnt) begin
            failCount++;
            $display("[TB] FAIL reset_store_grant: got no grant, expected grant");
        end
        @(posedge clk); #1;
        dm_req_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        assertCount++;
        if (allOut !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_async_outputs: got %h, expected all zero", allOut);
        end
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        rvalidSeen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (dm_rvalid_o || if_rvalid_o || mem_write_en_o || mem_read_en_o) rvalidSeen++;
        end
        assertCount++;
        if (rvalidSeen != 0) begin
            failCount++;
            $display("[TB] FAIL reset_no_response: got %0d active cycles after reset, expected 0", rvalidSeen);
        end
        memWord = {envMem[12'h023], envMem[12'h022], envMem[12'h021], envMem[12'h020]};
        assertCount++;
        if (memWord !== expWord) begin
            failCount++;
            $display("[TB] FAIL reset_partial_bytes: got %h, expected %h", memWord, expWord);
        end
        refMem[12'h020] = wdata[7:0];
        refMem[12'h021] = wdata[15:8];
        @(posedge clk); #1;
        doLoadCheck("post_reset_load", 2'b10, 32'h0100_0020);
    endtask

    initial begin
        clearMem();
        preloadWord(32'h0100_0000, 32'h0050_0093);
        preloadWord(32'h0100_0020, 32'h7766_5544);
        test_reset();
        test_contention();
        test_fetch();
        test_store_load();
        test_sub_word_loads();
        test_misaligned_half();
        test_wrap();
        test_random();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single byte-addressable memory port between the instruction-fetch requester (IF, read-only) and the data requester (DM, load/store).
- The memory port has a combinational word read and writes one byte per posedge, so this block splits each DM store into 1/2/4 byte-write beats.
- Sits between the fetch/LSU logic and the memory instance, and passes absolute CPU addresses straight through.

Parameters:
AWIDTH, 32, address width of all address ports
DWIDTH, 32, data width of all data ports

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
if_req_i  input  1  fetch request; held with if_addr_i stable until if_gnt_o
if_addr_i  input  AWIDTH  fetch byte address
if_gnt_o  output  1  fetch request accepted this cycle
if_rvalid_o  output  1  one-cycle pulse, if_rdata_o valid
if_rdata_o  output  DWIDTH  fetched word
dm_req_i  input  1  data request; held with dm_* stable until dm_gnt_o
dm_we_i  input  1  1 = store, 0 = load
dm_size_i  input  2  00 byte, 01 half, 10 word, 11 treated as word
dm_addr_i  input  AWIDTH  data byte address (misaligned allowed)
dm_wdata_i  input  DWIDTH  store data, LSB byte written first
dm_gnt_o  output  1  data request accepted this cycle
dm_rvalid_o  output  1  one-cycle pulse: load data valid or store complete
dm_rdata_o  output  DWIDTH  load data, zero-extended to size; 0 for stores
mem_addr_o  output  AWIDTH  memory address
mem_data_o  output  DWIDTH  memory write data (only [7:0] meaningful)
mem_read_en_o  output  1  memory read enable
mem_write_en_o  output  1  memory byte write enable
mem_data_i  input  DWIDTH  memory combinational read data

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, last_gnt=IF (so DM wins the first tie), beat counter=0.
  - All outputs are 0, including both rdata registers.
  - Bytes already written by an interrupted store stay in memory. No response is issued for the aborted request.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - Grant arbitration is combinational.
    - Only one requester active: that requester is granted.
    - Both active: the port not in last_gnt is granted (round-robin).
  - The granted port's gnt_o is high for exactly that cycle, only in IDLE.
  - At the posedge: latch owner, addr, we, size and wdata; update last_gnt.
  - Next state: load or fetch -> READ; store -> WRITE. No request -> stay in IDLE.
- READ (1 cycle):
  - mem_read_en_o=1, mem_addr_o=latched addr.
  - At the posedge, the owner's rdata register captures mem_data_i masked by size: byte -> [7:0], half -> [15:0], word -> all bits. Upper bits are 0.
  - Next state: RESP.
- WRITE (N = 1/2/4 cycles per size):
  - mem_write_en_o=1, mem_addr_o = addr + beat, mem_data_o = {24'b0, wdata[8*beat +: 8]}.
  - beat increments each posedge. After beat N-1 -> RESP; dm_rdata_o is cleared to 0.
- RESP (1 cycle): the owner's rvalid_o=1, then IDLE. No grant is given in RESP.
- Response data: if_rdata_o / dm_rdata_o hold their last value until the next capture.
- Latency (grant cycle = T):
  - Load/fetch: rvalid at T+2.
  - Store: rvalid at T+N+1.
  - Minimum spacing between grants: 3 cycles for reads, N+2 for stores.
- Memory port defaults when not in READ/WRITE: mem_read_en_o=0, mem_write_en_o=0, mem_addr_o=0, mem_data_o=0.
- Address arithmetic: addr + beat is modulo 2^AWIDTH (wraps silently).
- A request that drops req before gnt is simply not served. A request arriving during READ/WRITE/RESP waits.
- Only one transaction is outstanding at a time; requests are never reordered across ports.

Test Plan:
- Reset mid-store: word store in flight, rst low after beat 1 -> all outputs 0 immediately (async); only bytes 0-1 are written; IDLE after release with no dm_rvalid_o.
- Fetch: if_req_i=1, if_addr_i=0x01000000 (memory holds 0x00500093) -> if_gnt_o at T, mem_read_en_o at T+1, if_rvalid_o at T+2 with if_rdata_o=0x00500093.
- Word store then load:
  - Store: size=10, addr=0x01000010, wdata=0xDEADBEEF -> writes EF, BE, AD, DE at 0x..10 to 0x..13 on T+1..T+4; dm_rvalid_o at T+5 with dm_rdata_o=0.
  - Load: word load at 0x01000010 -> 0xDEADBEEF.
- Byte and half loads at 0x01000011 over the same data: byte -> 0x000000BE, half -> 0x0000ADBE.
- Contention: both requests held from reset -> DM granted first, then IF; with both held continuously, grants alternate DM, IF, DM, IF.
- Misaligned half store: addr=0x01000003, wdata=0x1234 -> 0x34 at 0x..03, 0x12 at 0x..04; dm_rvalid_o at T+3.
